y_mat_addr_fetch: RTL and testbench

Y_MAT_ADDR_FETCH -- requirements
Module: y_mat_addr_fetch

---
 rtl/y_mat_addr_fetch.sv | 116 +++++++++++
 tb/tb_y_mat_addr_fetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_mat_addr_fetch.sv
// Y-matrix address fetch: reads one memory word per request and returns either
// one addressed lane field or a scan of every lane field, one per handshake.
module y_mat_addr_fetch #(
  parameter int LANES   = 16,
  parameter int LANE_W  = 16,
  parameter int FIELD_W = 11,
  parameter int ROW_W   = 16,
  parameter int MEM_AW  = 12,
  parameter int RD_LAT  = 1,
  localparam int DATA_W = LANES * LANE_W,
  localparam int LW     = $clog2(LANES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROW_W-1:0]  req_row,
  input  logic              req_mode,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [FIELD_W-1:0] rsp_addr,
  output logic [LW-1:0]     rsp_lane,
  output logic              rsp_last
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam int CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  logic [1:0]         state;
  logic [CW-1:0]      waitCnt;
  logic [LW-1:0]      lane;
  logic               scanMode;
  logic [DATA_W-1:0]  wordReg;
  logic [MEM_AW-1:0]  memAddrReg;
  logic [FIELD_W-1:0] fields [LANES];
  logic               inOut;
  logic               lastNow;
  logic               accept;
  logic               unusedWordBits;

  assign req_ready = reset && enable && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign inOut     = (state == OUT);
  assign lastNow   = !scanMode || (lane == LW'(LANES - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      lane       <= '0;
      scanMode   <= 1'b0;
      wordReg    <= '0;
      memAddrReg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RD;
            memAddrReg <= MEM_AW'(req_row >> LW);
            lane       <= req_mode ? '0 : req_row[LW-1:0];
            scanMode   <= req_mode;
          end
        end
        RD: begin
          state   <= WAIT;
          waitCnt <= CW'(1);
        end
        // Memory word becomes valid RD_LAT cycles after the read strobe
        WAIT: begin
          if (waitCnt == CW'(RD_LAT)) begin
            wordReg <= mem_rd_data;
            state   <= OUT;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        OUT: begin
          if (rsp_ready) begin
            if (lastNow) begin
              state <= IDLE;
              lane  <= '0;
            end else begin
              lane <= lane + LW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane 0 sits in the most significant lane; the field is the low part of each lane
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      fields[i] = wordReg[DATA_W-1-i*LANE_W-(LANE_W-FIELD_W) -: FIELD_W];
    end
  end

  assign unusedWordBits = ^wordReg;

  assign mem_rd_en = (state == RD);
  assign mem_addr  = memAddrReg;
  assign rsp_valid = inOut;
  assign rsp_addr  = inOut ? fields[lane] : '0;
  assign rsp_lane  = inOut ? lane : '0;
  assign rsp_last  = inOut && lastNow;

endmodule

// File: tb/tb_y_mat_addr_fetch.sv
// Bench for y_mat_addr_fetch: two instances (read latency 1 and 3) checked every
// cycle against a request-level model, plus directed literal expectations.
module tb_y_mat_addr_fetch;

  localparam int LANES   = 16;
  localparam int LANE_W  = 16;
  localparam int FIELD_W = 11;
  localparam int DATA_W  = LANES * LANE_W;

  logic clock = 1'b0;
  logic reset;
  logic enable;

  logic              reqValidA, reqReadyA, reqModeA, memRdEnA, rspValidA, rspReadyA, rspLastA;
  logic [15:0]       reqRowA;
  logic [11:0]       memAddrA;
  logic [DATA_W-1:0] memRdDataA = '0;
  logic [10:0]       rspAddrA;
  logic [3:0]        rspLaneA;

  logic              reqValidB, reqReadyB, reqModeB, memRdEnB, rspValidB, rspReadyB, rspLastB;
  logic [15:0]       reqRowB;
  logic [11:0]       memAddrB;
  logic [DATA_W-1:0] memRdDataB = '0;
  logic [10:0]       rspAddrB;
  logic [3:0]        rspLaneB;

  y_mat_addr_fetch dutA (
    .clock(clock), .reset(reset), .enable(enable),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_row(reqRowA), .req_mode(reqModeA),
    .mem_rd_en(memRdEnA), .mem_addr(memAddrA), .mem_rd_data(memRdDataA),
    .rsp_valid(rspValidA), .rsp_ready(rspReadyA), .rsp_addr(rspAddrA),
    .rsp_lane(rspLaneA), .rsp_last(rspLastA)
  );

  y_mat_addr_fetch #(.RD_LAT(3)) dutB (
    .clock(clock), .reset(reset), .enable(enable),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_row(reqRowB), .req_mode(reqModeB),
    .mem_rd_en(memRdEnB), .mem_addr(memAddrB), .mem_rd_data(memRdDataB),
    .rsp_valid(rspValidB), .rsp_ready(rspReadyB), .rsp_addr(rspAddrB),
    .rsp_lane(rspLaneB), .rsp_last(rspLastB)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit checking = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory image: per word address, per lane, the address field plus junk upper bits
  logic [10:0] fieldTab [16][16];
  logic [4:0]  junkTab  [16][16];

  // Request-level model state, index 0 = instance A, 1 = instance B
  bit          active    [2] = '{1'b0, 1'b0};
  int          acceptCyc [2] = '{0, 0};
  int          lat       [2] = '{1, 3};
  logic [3:0]  mWa       [2] = '{4'd0, 4'd0};
  bit          mMode     [2] = '{1'b0, 1'b0};
  logic [3:0]  mLane     [2] = '{4'd0, 4'd0};
  logic [11:0] lastAddr  [2] = '{12'd0, 12'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] buildWord(input logic [3:0] a);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < LANES; i++) w[(LANES-1-i)*LANE_W +: LANE_W] = {junkTab[a][i], fieldTab[a][i]};
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] randWord();
    logic [DATA_W-1:0] w;
    for (int j = 0; j < DATA_W / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic checkDut(input int d, input logic rr, input logic re, input logic [11:0] ma,
                          input logic rv, input logic [10:0] ra, input logic [3:0] rl, input logic rlst);
    string p;
    logic eValid;
    p = (d == 0) ? "A" : "B";
    eValid = active[d] && (cyc >= acceptCyc[d] + 2 + lat[d]);
    chk({p, ".req_ready"}, rr, reset && enable && !active[d]);
    chk({p, ".mem_rd_en"}, re, active[d] && (cyc == acceptCyc[d] + 1));
    chk({p, ".mem_addr"}, ma, lastAddr[d]);
    chk({p, ".rsp_valid"}, rv, eValid);
    chk({p, ".rsp_addr"}, ra, eValid ? fieldTab[mWa[d]][mLane[d]] : 11'd0);
    chk({p, ".rsp_lane"}, rl, eValid ? mLane[d] : 4'd0);
    chk({p, ".rsp_last"}, rlst, eValid && (!mMode[d] || mLane[d] == 4'd15));
  endtask

  task automatic stepModel(input int d, input logic rqv, input logic [15:0] row, input logic mode,
                           input logic rdy);
    if (!reset) begin
      active[d]   = 1'b0;
      lastAddr[d] = '0;
    end else if (active[d]) begin
      if (cyc >= acceptCyc[d] + 2 + lat[d] && rdy) begin
        if (!mMode[d] || mLane[d] == 4'd15) active[d] = 1'b0;
        else mLane[d] = mLane[d] + 4'd1;
      end
    end else if (enable && rqv) begin
      active[d]    = 1'b1;
      acceptCyc[d] = cyc;
      mWa[d]       = row[7:4];
      mMode[d]     = mode;
      mLane[d]     = mode ? 4'd0 : row[3:0];
      lastAddr[d]  = row[15:4];
    end
  endtask

  // Compare, then advance the model across the edge that ends this cycle
  always @(negedge clock) begin
    if (checking) begin
      checkDut(0, reqReadyA, memRdEnA, memAddrA, rspValidA, rspAddrA, rspLaneA, rspLastA);
      checkDut(1, reqReadyB, memRdEnB, memAddrB, rspValidB, rspAddrB, rspLaneB, rspLastB);
    end
    stepModel(0, reqValidA, reqRowA, reqModeA, rspReadyA);
    stepModel(1, reqValidB, reqRowB, reqModeB, rspReadyB);
  end

  // Memories: valid data only in the cycle RD_LAT after the strobe, noise otherwise
  int dueA = 0, dueB = 0;
  logic [3:0] addrA = '0, addrB = '0;
  always @(negedge clock) begin
    memRdDataA = (dueA == 1) ? buildWord(addrA) : randWord();
    if (dueA > 0) dueA--;
    if (memRdEnA === 1'b1) begin dueA = 1; addrA = memAddrA[3:0]; end
    memRdDataB = (dueB == 1) ? buildWord(addrB) : randWord();
    if (dueB > 0) dueB--;
    if (memRdEnB === 1'b1) begin dueB = 3; addrB = memAddrB[3:0]; end
  end

  task automatic sendA(input logic [15:0] row, input logic mode);
    reqValidA = 1'b1; reqRowA = row; reqModeA = mode;
    @(posedge clock); #1;
    reqValidA = 1'b0;
  endtask

  task automatic sendB(input logic [15:0] row, input logic mode);
    reqValidB = 1'b1; reqRowB = row; reqModeB = mode;
    @(posedge clock); #1;
    reqValidB = 1'b0;
  endtask

  task automatic waitIdle(input int d);
    int n;
    n = 0;
    @(posedge clock); #1;
    while (active[d] && n < 100) begin @(posedge clock); #1; n++; end
    chk((d == 0) ? "A.idle_timeout" : "B.idle_timeout", active[d], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int a = 0; a < 16; a++)
      for (int i = 0; i < 16; i++) begin
        fieldTab[a][i] = 11'($urandom);
        junkTab[a][i]  = 5'($urandom);
      end
    fieldTab[0][3]  = 11'h5AB;
    fieldTab[1][15] = 11'h7FF;
    junkTab[1][15]  = 5'h1F;
    fieldTab[1][3]  = 11'h2C5;
    for (int i = 0; i < 16; i++) fieldTab[2][i] = 11'(i + 1);

    reset = 1'b0; enable = 1'b1;
    reqValidA = 1'b1; reqRowA = 16'h0003; reqModeA = 1'b0; rspReadyA = 1'b1;
    reqValidB = 1'b0; reqRowB = 16'h0000; reqModeB = 1'b0; rspReadyB = 1'b1;
    repeat (2) @(posedge clock);
    #1; checking = 1'b1;

    // Request offered while reset is held low
    @(negedge clock);
    chk("rst.req_ready", reqReadyA, 0);
    chk("rst.rsp_valid", rspValidA, 0);
    chk("rst.mem_addr", memAddrA, 0);
    @(posedge clock); #1;
    reqValidA = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk("idle.req_ready", reqReadyA, 1);
    chk("idle.mem_rd_en", memRdEnA, 0);
    @(posedge clock); #1;

    // Mode 0, row 3 -> word 0 lane 3
    sendA(16'h0003, 1'b0);
    @(negedge clock);
    chk("m0.mem_rd_en", memRdEnA, 1);
    chk("m0.mem_addr", memAddrA, 12'h000);
    @(negedge clock);
    chk("m0.early_valid", rspValidA, 0);
    @(negedge clock);
    chk("m0.rsp_valid", rspValidA, 1);
    chk("m0.rsp_addr", rspAddrA, 11'h5AB);
    chk("m0.rsp_lane", rspLaneA, 3);
    chk("m0.rsp_last", rspLastA, 1);
    waitIdle(0);

    // Mode 0, row 0x1F -> word 1 lane 15, junk upper bits all ones
    sendA(16'h001F, 1'b0);
    @(negedge clock);
    chk("m0b.mem_addr", memAddrA, 12'h001);
    @(negedge clock);
    @(negedge clock);
    chk("m0b.rsp_addr", rspAddrA, 11'h7FF);
    chk("m0b.rsp_lane", rspLaneA, 15);
    waitIdle(0);

    // Mode 1 scan of word 2 with a 4-cycle stall on lane 2
    sendA(16'h0020, 1'b1);
    repeat (4) begin @(posedge clock); #1; end
    rspReadyA = 1'b0;
    repeat (4) begin
      @(negedge clock);
      chk("scan.hold_lane", rspLaneA, 2);
      chk("scan.hold_addr", rspAddrA, 11'd3);
      @(posedge clock); #1;
    end
    rspReadyA = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!(rspValidA && rspLastA) && n < 40);
    chk("scan.last_addr", rspAddrA, 11'd16);
    chk("scan.last_lane", rspLaneA, 15);
    waitIdle(0);

    // Reset during scan lane 7, then a fresh request
    sendA(16'h0020, 1'b1);
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b0;
    @(negedge clock);
    chk("rstscan.lane7", rspLaneA, 7);
    chk("rstscan.addr8", rspAddrA, 11'd8);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rstscan.rsp_valid", rspValidA, 0);
    chk("rstscan.rsp_addr", rspAddrA, 0);
    chk("rstscan.rsp_lane", rspLaneA, 0);
    chk("rstscan.rsp_last", rspLastA, 0);
    chk("rstscan.mem_addr", memAddrA, 0);
    @(posedge clock); #1;
    sendA(16'h0003, 1'b0);
    @(negedge clock); @(negedge clock); @(negedge clock);
    chk("rstscan.after_valid", rspValidA, 1);
    chk("rstscan.after_addr", rspAddrA, 11'h5AB);
    waitIdle(0);

    // enable low blocks acceptance; dropping it mid-request does not
    enable = 1'b0;
    reqValidA = 1'b1; reqRowA = 16'h0003; reqModeA = 1'b0;
    repeat (3) begin
      @(negedge clock);
      chk("en0.req_ready", reqReadyA, 0);
      chk("en0.mem_rd_en", memRdEnA, 0);
      @(posedge clock); #1;
    end
    reqValidA = 1'b0; enable = 1'b1;
    sendA(16'h0013, 1'b0);
    enable = 1'b0;
    @(negedge clock); @(negedge clock); @(negedge clock);
    chk("en.drop_valid", rspValidA, 1);
    chk("en.drop_addr", rspAddrA, 11'h2C5);
    waitIdle(0);
    enable = 1'b1;

    // Read latency 3 instance
    sendB(16'h0013, 1'b0);
    @(negedge clock);
    chk("lat3.mem_rd_en", memRdEnB, 1);
    chk("lat3.mem_addr", memAddrB, 12'h001);
    @(negedge clock); @(negedge clock); @(negedge clock);
    chk("lat3.early_valid", rspValidB, 0);
    @(negedge clock);
    chk("lat3.rsp_valid", rspValidB, 1);
    chk("lat3.rsp_addr", rspAddrB, 11'h2C5);
    chk("lat3.rsp_lane", rspLaneB, 3);
    waitIdle(1);
    sendB(16'h0020, 1'b1);
    waitIdle(1);

    // Mixed requests with irregular consumer back-pressure
    for (int t = 0; t < 8; t++) begin
      sendA(16'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      n = 0;
      while (active[0] && n < 200) begin
        rspReadyA = 1'($urandom_range(0, 1));
        @(posedge clock); #1;
        n++;
      end
      chk("rand.timeout", active[0], 0);
      rspReadyA = 1'b1;
      @(posedge clock); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
